// File: rtl/cla_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial CLA subtractor.
// The master issues start/a/b; the slave returns busy/done and the result.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
endinterface

// File: rtl/cla_serial_subtractor.sv
// Digit-serial two's-complement subtractor: a - b computed as a + ~b + 1,
// one 4-bit lookahead slice per clock, least-significant slice first.
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  cla_serial_subtractor_if.slave  io_sub
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_diff;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_borrow;
  logic             r_ovf;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [3:0]       w_c;
  logic [3:0]       w_sum;
  logic             w_last;

  // Flat lookahead carries c0..c3 of one 4-bit slice, no ripple between bits.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  assign w_g    = r_opa[{r_idx, 2'b00} +: 4] & r_opb[{r_idx, 2'b00} +: 4];
  assign w_p    = r_opa[{r_idx, 2'b00} +: 4] ^ r_opb[{r_idx, 2'b00} +: 4];
  assign w_c    = cla4_carries(w_g, w_p, r_carry);
  assign w_sum  = w_p ^ {w_c[2:0], r_carry};
  assign w_last = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_sub.start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-slice datapath and registered result/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      // done trails the DONE state by one edge so it aligns with the settled result
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (io_sub.start) begin
            r_opa   <= io_sub.a;
            r_opb   <= ~io_sub.b;
            r_carry <= 1'b1;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_diff[{r_idx, 2'b00} +: 4] <= w_sum;
          r_carry <= w_c[3];
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_borrow <= ~w_c[3];
            r_ovf    <= (r_opa[WIDTH-1] != ~r_opb[WIDTH-1]) & (w_sum[3] != r_opa[WIDTH-1]);
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign io_sub.busy   = r_busy;
  assign io_sub.done   = r_done;
  assign io_sub.diff   = r_diff;
  assign io_sub.borrow = r_borrow;
  assign io_sub.ovf    = r_ovf;
endmodule
